// File: rtl/ad_ip_jesd204_tpl_dac_xfer_ctrl.sv
// ad_ip_jesd204_tpl_dac_xfer_ctrl
//   Transfer/sync controller between the DMA interface and the TPL DAC channel
//   datapaths: external-sync arming with trigger modes and a programmable
//   trigger delay, per-channel enables, link_ready back-pressure and a sticky
//   DMA-underflow flag.
// Ports
//   clk, resetn            core clock (posedge), asynchronous active-low reset
//   link_ready/link_valid  link handshake (link_valid high from first edge after reset)
//   dac_valid              per-channel DMA read strobe
//   dac_ddata, dac_dunf    DMA samples and underflow indication
//   dac_data               registered, zero-filled samples to the channels
//   data_sync              one-cycle PN/DDS resync pulse
//   dac_external_sync      external trigger pin (asynchronous)
//   cfg_sync_*             arm/disarm/manual pulses, trigger mode, trigger delay
//   cfg_chan_enable        channel enable mask
//   cfg_unf_clr            clears the underflow sticky flag
//   sync_status            FSM state (0 RUN, 1 ARMED, 2 DELAY)
//   unf_status             sticky underflow flag
module ad_ip_jesd204_tpl_dac_xfer_ctrl #(
  parameter int NUM_CHANNELS     = 1,
  parameter int DMA_CDW          = 64,
  parameter int SYNC_DELAY_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             link_ready,
  output logic                             link_valid,
  output logic [NUM_CHANNELS-1:0]          dac_valid,
  input  logic [NUM_CHANNELS*DMA_CDW-1:0]  dac_ddata,
  input  logic                             dac_dunf,
  output logic [NUM_CHANNELS*DMA_CDW-1:0]  dac_data,
  output logic                             data_sync,
  input  logic                             dac_external_sync,
  input  logic                             cfg_sync_arm,
  input  logic                             cfg_sync_disarm,
  input  logic                             cfg_sync_manual,
  input  logic [1:0]                       cfg_sync_mode,
  input  logic [SYNC_DELAY_WIDTH-1:0]      cfg_sync_delay,
  input  logic [NUM_CHANNELS-1:0]          cfg_chan_enable,
  input  logic                             cfg_unf_clr,
  output logic [1:0]                       sync_status,
  output logic                             unf_status
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2
  } state_t;

  localparam logic [SYNC_DELAY_WIDTH-1:0] DLY_ONE = {{(SYNC_DELAY_WIDTH-1){1'b0}}, 1'b1};

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [SYNC_DELAY_WIDTH-1:0]     r_cnt;
  logic [SYNC_DELAY_WIDTH-1:0]     w_cnt_nxt;
  logic                            r_data_sync;
  logic                            w_data_sync_nxt;
  logic                            r_link_valid;
  logic                            r_unf;
  logic [NUM_CHANNELS*DMA_CDW-1:0] r_dac_data;

  logic                            r_ext_meta;
  logic                            r_ext_s;
  logic                            r_ext_d;
  logic                            w_edge;
  logic                            w_trig;
  logic                            w_run;
  logic [NUM_CHANNELS-1:0]         w_dac_valid;

  // Two-flop synchroniser plus a history flop that always tracks, so a level
  // already held before arming never looks like a fresh edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ext_meta <= 1'b0;
      r_ext_s    <= 1'b0;
      r_ext_d    <= 1'b0;
    end else begin
      r_ext_meta <= dac_external_sync;
      r_ext_s    <= r_ext_meta;
      r_ext_d    <= r_ext_s;
    end
  end

  always_comb begin
    w_edge = 1'b0;
    case (cfg_sync_mode)
      2'd0:    w_edge = r_ext_s & ~r_ext_d;
      2'd1:    w_edge = ~r_ext_s & r_ext_d;
      2'd2:    w_edge = r_ext_s;
      default: w_edge = 1'b0;
    endcase
    w_trig = w_edge | cfg_sync_manual;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_data_sync <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_data_sync <= w_data_sync_nxt;
    end
  end

  // Disarm is checked first in ARMED/DELAY so it wins over a same-cycle trigger.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_data_sync_nxt = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (cfg_sync_arm && !cfg_sync_disarm) begin
          w_state_nxt = ST_ARMED;
        end
        if (cfg_sync_manual) begin
          w_data_sync_nxt = 1'b1;
        end
      end
      ST_ARMED: begin
        if (cfg_sync_disarm) begin
          w_state_nxt = ST_RUN;
        end else if (w_trig) begin
          if (cfg_sync_delay == '0) begin
            w_state_nxt     = ST_RUN;
            w_data_sync_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DELAY;
            w_cnt_nxt   = cfg_sync_delay - DLY_ONE;
          end
        end
      end
      ST_DELAY: begin
        if (cfg_sync_disarm) begin
          w_state_nxt = ST_RUN;
        end else if (r_cnt == '0) begin
          w_state_nxt     = ST_RUN;
          w_data_sync_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - DLY_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_run       = (r_state == ST_RUN);
  assign w_dac_valid = {NUM_CHANNELS{w_run & link_ready}} & cfg_chan_enable;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_link_valid <= 1'b0;
    end else begin
      r_link_valid <= 1'b1;
    end
  end

  // Samples are held while the link stalls; disabled channels, non-RUN states
  // and underflow cycles emit zeros.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dac_data <= '0;
    end else if (link_ready) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        r_dac_data[i*DMA_CDW +: DMA_CDW] <=
          (w_run && cfg_chan_enable[i] && !dac_dunf) ? dac_ddata[i*DMA_CDW +: DMA_CDW] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_unf <= 1'b0;
    end else if (dac_dunf && |w_dac_valid) begin
      r_unf <= 1'b1;
    end else if (cfg_unf_clr) begin
      r_unf <= 1'b0;
    end
  end

  assign link_valid  = r_link_valid;
  assign dac_valid   = w_dac_valid;
  assign dac_data    = r_dac_data;
  assign data_sync   = r_data_sync;
  assign sync_status = r_state;
  assign unf_status  = r_unf;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_xfer_ctrl.sv
module tb_ad_ip_jesd204_tpl_dac_xfer_ctrl;

  localparam int NCH = 2;
  localparam int CDW = 16;
  localparam int DW  = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             link_ready = 1'b1;
  logic             link_valid;
  logic [NCH-1:0]   dac_valid;
  logic [NCH*CDW-1:0] dac_ddata = '0;
  logic             dac_dunf = 1'b0;
  logic [NCH*CDW-1:0] dac_data;
  logic             data_sync;
  logic             ext_sync = 1'b0;
  logic             arm = 1'b0;
  logic             disarm = 1'b0;
  logic             manual = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [DW-1:0]    delay = '0;
  logic [NCH-1:0]   en = 2'b11;
  logic             unf_clr = 1'b0;
  logic [1:0]       sync_status;
  logic             unf_status;

  ad_ip_jesd204_tpl_dac_xfer_ctrl #(
    .NUM_CHANNELS(NCH),
    .DMA_CDW(CDW),
    .SYNC_DELAY_WIDTH(DW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .link_ready(link_ready),
    .link_valid(link_valid),
    .dac_valid(dac_valid),
    .dac_ddata(dac_ddata),
    .dac_dunf(dac_dunf),
    .dac_data(dac_data),
    .data_sync(data_sync),
    .dac_external_sync(ext_sync),
    .cfg_sync_arm(arm),
    .cfg_sync_disarm(disarm),
    .cfg_sync_manual(manual),
    .cfg_sync_mode(mode),
    .cfg_sync_delay(delay),
    .cfg_chan_enable(en),
    .cfg_unf_clr(unf_clr),
    .sync_status(sync_status),
    .unf_status(unf_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           lv;
    logic           run;
    logic [NCH*CDW-1:0] data;
    logic           ds;
    logic [1:0]     st;
    logic           unf;
  } rec_t;

  rec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   started = 0;
  bit   in_rst_win = 0;

  // Reference model: trigger seen at edge t uses the pin as sampled two and
  // three edges earlier; a delayed trigger fires at an absolute edge number.
  int unsigned t;
  int unsigned fire_at;
  int          m_st;
  logic        m_unf;
  logic [NCH*CDW-1:0] m_data;
  logic        p1, p2, p3;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_st = 0; t = 0; fire_at = 0; m_unf = 0; m_data = '0;
      p1 = 0; p2 = 0; p3 = 0;
      q.delete();
      in_rst_win = 1;
      started = 1;
    end else begin : mdl
      logic trig, ds, run_b, dv_any;
      rec_t r;
      t++;
      ds = 0;
      run_b = (m_st == 0);
      case (mode)
        2'd0: trig = p2 & ~p3;
        2'd1: trig = ~p2 & p3;
        2'd2: trig = p2;
        default: trig = 0;
      endcase
      trig = trig | manual;
      dv_any = run_b & link_ready & (|en);
      if (link_ready)
        for (int ch = 0; ch < NCH; ch++)
          m_data[ch*CDW +: CDW] = (run_b && en[ch] && !dac_dunf) ? dac_ddata[ch*CDW +: CDW] : '0;
      if (dac_dunf && dv_any) m_unf = 1;
      else if (unf_clr) m_unf = 0;
      if (m_st == 0) begin
        if (arm && !disarm) m_st = 1;
        if (manual) ds = 1;
      end else if (m_st == 1) begin
        if (disarm) m_st = 0;
        else if (trig) begin
          if (delay == 0) begin m_st = 0; ds = 1; end
          else begin m_st = 2; fire_at = t + delay; end
        end
      end else begin
        if (disarm) m_st = 0;
        else if (t == fire_at) begin m_st = 0; ds = 1; end
      end
      p3 = p2; p2 = p1; p1 = ext_sync;
      r.lv = 1; r.run = (m_st == 0); r.data = m_data; r.ds = ds;
      r.st = m_st[1:0]; r.unf = m_unf;
      q.push_back(r);
      in_rst_win = 0;
    end
  end

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (started) begin : mon
      rec_t e;
      logic [NCH-1:0] edv;
      bit ok;
      ok = 1;
      if (!resetn || (q.size() == 0 && in_rst_win)) begin
        e.lv = 0; e.run = 1; e.data = '0; e.ds = 0; e.st = 0; e.unf = 0;
      end else if (q.size() == 0) begin
        ok = 0;
        e.lv = 0; e.run = 1; e.data = '0; e.ds = 0; e.st = 0; e.unf = 0;
        $display("FAIL no_expectation at %0t", $time);
      end else begin
        e = q.pop_front();
      end
      edv = {NCH{e.run & link_ready}} & en;
      vectors++;
      if (ok && (link_valid !== e.lv || dac_valid !== edv || dac_data !== e.data ||
                 data_sync !== e.ds || sync_status !== e.st || unf_status !== e.unf)) begin
        ok = 0;
        $display("FAIL outputs at %0t: got lv=%b dv=%b data=%h ds=%b st=%0d unf=%b, want lv=%b dv=%b data=%h ds=%b st=%0d unf=%b",
                 $time, link_valid, dac_valid, dac_data, data_sync, sync_status, unf_status,
                 e.lv, edv, e.data, e.ds, e.st, e.unf);
      end
      if (!ok) miscompares++;
    end
  end

  always @(posedge clk) begin
    #1 dac_ddata = $urandom;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_arm();
    arm = 1; cyc(1); arm = 0;
  endtask

  initial begin
    #2 resetn = 0;
    cyc(3);
    resetn = 1;
    cyc(10);

    // rising edge, zero delay
    mode = 0; delay = 0; ext_sync = 0;
    pulse_arm();
    cyc(3);
    ext_sync = 1; cyc(6);
    ext_sync = 0; cyc(3);

    // pre-held level then a real edge, delay 5
    ext_sync = 1; cyc(4);
    delay = 5;
    pulse_arm();
    cyc(5);
    ext_sync = 0; cyc(2);
    ext_sync = 1; cyc(1);
    delay = 0; cyc(12);

    // disarm together with trigger, then disarm during delay
    pulse_arm(); cyc(2);
    manual = 1; disarm = 1; cyc(1); manual = 0; disarm = 0; cyc(3);
    delay = 5; pulse_arm(); cyc(1);
    manual = 1; cyc(1); manual = 0; cyc(2);
    disarm = 1; cyc(1); disarm = 0; cyc(8);

    // manual sync in RUN, falling and level modes
    manual = 1; cyc(1); manual = 0; cyc(3);
    mode = 1; delay = 2; pulse_arm(); cyc(2); ext_sync = 0; cyc(8);
    mode = 2; delay = 0; ext_sync = 1; pulse_arm(); cyc(5); ext_sync = 0;
    mode = 0; cyc(3);

    // back-pressure and channel mask
    link_ready = 0; cyc(3); link_ready = 1; cyc(2);
    en = 2'b01; cyc(4); en = 2'b11; cyc(2);

    // underflow sticky
    dac_dunf = 1; cyc(1); dac_dunf = 0; cyc(2);
    dac_dunf = 1; unf_clr = 1; cyc(1); dac_dunf = 0; unf_clr = 0; cyc(2);
    unf_clr = 1; cyc(1); unf_clr = 0; cyc(2);

    // reset in the middle of a delay
    delay = 20; pulse_arm(); cyc(1);
    manual = 1; cyc(1); manual = 0; cyc(5);
    resetn = 0; cyc(2); resetn = 1; cyc(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arm        = ($urandom_range(7) == 0);
      disarm     = ($urandom_range(29) == 0);
      manual     = ($urandom_range(24) == 0);
      if ($urandom_range(49) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(5) == 0) ext_sync = ~ext_sync;
      link_ready = ($urandom_range(99) < 85);
      if ($urandom_range(19) == 0) en = 2'($urandom_range(3));
      dac_dunf   = ($urandom_range(14) == 0);
      unf_clr    = ($urandom_range(19) == 0);
      delay      = 8'($urandom_range(6));
      if ($urandom_range(499) == 0) begin
        resetn = 0; cyc(2); resetn = 1;
      end
      cyc(1);
    end
    arm = 0; disarm = 0; manual = 0; dac_dunf = 0; unf_clr = 0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
